// File: rtl/unified_mem_arbiter.sv
// Fetch/data arbiter onto one single-ported unified memory with fixed read latency.
// Define MEM_ARB_RR_EN for round-robin grant; default build gives data fixed priority.
module unified_mem_arbiter #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned MEM_LAT = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                if_req_valid,
   input  logic [ADDR_W-1:0]   if_req_addr,
   output logic                if_req_ready,
   input  logic                if_flush,
   output logic                if_rsp_valid,
   output logic [DATA_W-1:0]   if_rsp_data,
   input  logic                d_req_valid,
   input  logic                d_req_we,
   input  logic [1:0]          d_req_size,
   input  logic [ADDR_W-1:0]   d_req_addr,
   input  logic [DATA_W-1:0]   d_req_wdata,
   output logic                d_req_ready,
   output logic                d_rsp_valid,
   output logic                d_rsp_err,
   output logic [DATA_W-1:0]   d_rsp_data,
   output logic                mem_en,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W/8-1:0] mem_wstrb,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata
);

   localparam int unsigned STRB_W = DATA_W / 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP,
      S_ERR
   } state_t;

   state_t              state, state_nx;
   logic [2:0]          cnt;
   logic                last_cnt;
   logic                can_accept;
   logic                grant_d, grant_if;
   logic                d_misalign;
   logic                req_fetch, req_we;
   logic [1:0]          req_size;
   logic [ADDR_W-1:0]   req_addr;
   logic [DATA_W-1:0]   req_wdata;
   logic                flushed;
   logic                if_pulse, d_pulse, d_err_q;
`ifdef MEM_ARB_RR_EN
   logic                last_fetch;
`endif

   assign last_cnt = (cnt == 3'(MEM_LAT - 1));

   always_comb begin
      case (d_req_size)
         2'b00:   d_misalign = 1'b0;
         2'b01:   d_misalign = d_req_addr[0];
         default: d_misalign = |d_req_addr[1:0];
      endcase
   end

   // Grant is combinational while the FSM can accept (IDLE or RESP).
   always_comb begin
      can_accept = ~reset & ((state == S_IDLE) | (state == S_RESP));
`ifdef MEM_ARB_RR_EN
      grant_d     = can_accept & d_req_valid & (~if_req_valid | last_fetch);
      grant_if    = can_accept & if_req_valid & (~d_req_valid | ~last_fetch);
      d_req_ready = can_accept & (~if_req_valid | last_fetch);
`else
      grant_d     = can_accept & d_req_valid;
      grant_if    = can_accept & if_req_valid & ~d_req_valid;
      d_req_ready = can_accept;
`endif
      if_req_ready = grant_if;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE, S_RESP: begin
            state_nx = S_IDLE;
            if (grant_d)       state_nx = d_misalign ? S_ERR : S_ISSUE;
            else if (grant_if) state_nx = S_ISSUE;
         end
         S_ISSUE: state_nx = S_WAIT;
         S_WAIT:  if (last_cnt) state_nx = S_RESP;
         S_ERR:   state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      mem_en    = (state == S_ISSUE);
      mem_we    = mem_en & req_we;
      mem_addr  = '0;
      mem_wstrb = '0;
      mem_wdata = '0;
      if (mem_en) mem_addr = {req_addr[ADDR_W-1:2], 2'b00};
      if (mem_we) begin
         case (req_size)
            2'b00: begin
               mem_wstrb = STRB_W'(4'b0001) << req_addr[1:0];
               mem_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
               mem_wstrb = STRB_W'(4'b0011) << {req_addr[1], 1'b0};
               mem_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
               mem_wstrb = '1;
               mem_wdata = req_wdata;
            end
         endcase
      end
      // A flush arriving in the RESP cycle itself still kills the fetch pulse.
      if_rsp_valid = if_pulse & ~if_flush;
      d_rsp_valid  = d_pulse;
      d_rsp_err    = d_err_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt         <= '0;
         req_fetch   <= 1'b0;
         req_we      <= 1'b0;
         req_size    <= '0;
         req_addr    <= '0;
         req_wdata   <= '0;
         flushed     <= 1'b0;
         if_pulse    <= 1'b0;
         d_pulse     <= 1'b0;
         d_err_q     <= 1'b0;
         if_rsp_data <= '0;
         d_rsp_data  <= '0;
`ifdef MEM_ARB_RR_EN
         last_fetch  <= 1'b1;
`endif
      end else begin
         if (state == S_WAIT) cnt <= cnt + 3'd1;
         else                 cnt <= '0;

         if (grant_d | grant_if) begin
            req_fetch <= grant_if;
            req_we    <= grant_d & d_req_we;
            req_size  <= d_req_size;
            req_addr  <= grant_d ? d_req_addr : if_req_addr;
            req_wdata <= d_req_wdata;
            flushed   <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_fetch <= grant_if;
`endif
         end else if (if_flush & req_fetch &
                      ((state == S_ISSUE) | (state == S_WAIT) | (state == S_RESP))) begin
            flushed <= 1'b1;
         end

         if_pulse <= 1'b0;
         d_pulse  <= 1'b0;
         d_err_q  <= 1'b0;
         if ((state == S_WAIT) && last_cnt) begin
            if (req_fetch) begin
               if (~flushed & ~if_flush) begin
                  if_pulse    <= 1'b1;
                  if_rsp_data <= mem_rdata;
               end
            end else begin
               d_pulse    <= 1'b1;
               d_rsp_data <= req_we ? '0 : mem_rdata;
            end
         end
         if (grant_d & d_misalign) begin
            d_pulse    <= 1'b1;
            d_err_q    <= 1'b1;
            d_rsp_data <= '0;
         end
      end
   end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed self-checking bench for unified_mem_arbiter with MEM_LAT=2 and a latency-accurate memory model.
module tb_unified_mem_arbiter;

   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 32;
   localparam int unsigned LAT = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          if_req_valid;
   logic [AW-1:0] if_req_addr;
   logic          if_req_ready;
   logic          if_flush;
   logic          if_rsp_valid;
   logic [DW-1:0] if_rsp_data;
   logic          d_req_valid;
   logic          d_req_we;
   logic [1:0]    d_req_size;
   logic [AW-1:0] d_req_addr;
   logic [DW-1:0] d_req_wdata;
   logic          d_req_ready;
   logic          d_rsp_valid;
   logic          d_rsp_err;
   logic [DW-1:0] d_rsp_data;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [3:0]    mem_wstrb;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   int total = 0;
   int bad   = 0;

   logic [31:0] mem [0:255];
   logic        pl_en;
   logic [7:0]  pl_idx;
   logic [31:0] pl_data;
   logic [31:0] pipe_d [LAT];
   logic        pipe_v [LAT];

   always #5 clk = ~clk;

   unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
      .clk(clk), .reset(reset),
      .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
      .if_flush(if_flush), .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
      .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_size(d_req_size),
      .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
      .d_rsp_valid(d_rsp_valid), .d_rsp_err(d_rsp_err), .d_rsp_data(d_rsp_data),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // Read data is only valid exactly LAT cycles after mem_en; otherwise a poison value.
   assign mem_rdata = pipe_v[LAT-1] ? pipe_d[LAT-1] : 32'hBAD0BAD0;

   always @(posedge clk) begin
      if (pl_en) mem[pl_idx] <= pl_data;
      else if (mem_en & mem_we)
         for (int b = 0; b < 4; b++)
            if (mem_wstrb[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
   end

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < LAT; i++) begin
            pipe_v[i] <= 1'b0;
            pipe_d[i] <= '0;
         end
      end else begin
         pipe_v[0] <= mem_en & ~mem_we;
         pipe_d[0] <= mem[mem_addr[9:2]];
         for (int i = 1; i < LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
         end
      end
   end

   task automatic clear_inputs;
      if_req_valid = 1'b0;
      if_req_addr  = '0;
      if_flush     = 1'b0;
      d_req_valid  = 1'b0;
      d_req_we     = 1'b0;
      d_req_size   = 2'b10;
      d_req_addr   = '0;
      d_req_wdata  = '0;
   endtask

   task automatic preload(input logic [7:0] idx, input logic [31:0] data);
      @(negedge clk);
      pl_en = 1'b1; pl_idx = idx; pl_data = data;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   task automatic test_reset;
      logic [31:0] lo;
      reset = 1'b1;
      pl_en = 1'b0; pl_idx = '0; pl_data = '0;
      clear_inputs();
      preload(8'h04, 32'hDEADBEEF);
      preload(8'h08, 32'hCAFEF00D);
      preload(8'h00, 32'h11111111);
      preload(8'h10, 32'h22222222);
      preload(8'h40, 32'h11223344);
      @(negedge clk);
      if_req_valid = 1'b1; d_req_valid = 1'b1; d_req_addr = 32'h40;
      #1;
      lo = {24'd0, if_req_ready, d_req_ready, mem_en, mem_we, if_rsp_valid, d_rsp_valid, d_rsp_err, |mem_wstrb};
      total++;
      if (lo !== 32'd0 || mem_addr !== '0 || if_rsp_data !== '0 || d_rsp_data !== '0) begin
         bad++;
         $display("FAIL reset_outputs got ctl=%h addr=%h ifd=%h dd=%h exp all 0", lo, mem_addr, if_rsp_data, d_rsp_data);
      end
      @(negedge clk);
      clear_inputs();
      reset = 1'b0;
      #1;
      total++;
      if (d_req_ready !== 1'b1 || if_req_ready !== 1'b0) begin
         bad++;
         $display("FAIL reset_ready got d=%b if=%b exp d=1 if=0", d_req_ready, if_req_ready);
      end
   endtask

   task automatic test_fetch;
      @(negedge clk);
      if_req_valid = 1'b1; if_req_addr = 32'h10;
      #1;
      total++;
      if (if_req_ready !== 1'b1) begin
         bad++; $display("FAIL fetch_ready got=%b exp=1", if_req_ready);
      end
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (k == 1) if_req_valid = 1'b0;
         #1;
         total++;
         if (mem_en !== (k == 1) || (k == 1 && (mem_addr !== 32'h10 || mem_we !== 1'b0))) begin
            bad++; $display("FAIL fetch_mem k=%0d got en=%b addr=%h we=%b exp en=%b addr=10", k, mem_en, mem_addr, mem_we, k == 1);
         end
         total++;
         if (if_rsp_valid !== (k == 4) || (k == 4 && if_rsp_data !== 32'hDEADBEEF)) begin
            bad++; $display("FAIL fetch_rsp k=%0d got v=%b d=%h exp v=%b d=deadbeef", k, if_rsp_valid, if_rsp_data, k == 4);
         end
      end
   endtask

   task automatic test_priority;
      @(negedge clk);
      if_req_valid = 1'b1; if_req_addr = 32'h0;
      d_req_valid = 1'b1; d_req_we = 1'b0; d_req_size = 2'b10; d_req_addr = 32'h40;
      #1;
      total++;
      if (d_req_ready !== 1'b1 || if_req_ready !== 1'b0) begin
         bad++; $display("FAIL prio_grant got d=%b if=%b exp d=1 if=0", d_req_ready, if_req_ready);
      end
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         if (k == 1) d_req_valid = 1'b0;
         if (k == 5) if_req_valid = 1'b0;
         #1;
         total++;
         if (mem_en !== (k == 1 || k == 5) ||
             (k == 1 && mem_addr !== 32'h40) || (k == 5 && mem_addr !== 32'h0)) begin
            bad++; $display("FAIL prio_mem k=%0d got en=%b addr=%h", k, mem_en, mem_addr);
         end
         total++;
         if (k <= 5 && if_req_ready !== (k == 4)) begin
            bad++; $display("FAIL prio_if_ready k=%0d got=%b exp=%b", k, if_req_ready, k == 4);
         end
         total++;
         if (d_rsp_valid !== (k == 4) || (k == 4 && d_rsp_data !== 32'h22222222)) begin
            bad++; $display("FAIL prio_d_rsp k=%0d got v=%b d=%h exp d=22222222", k, d_rsp_valid, d_rsp_data);
         end
         total++;
         if (if_rsp_valid !== (k == 8) || (k == 8 && if_rsp_data !== 32'h11111111)) begin
            bad++; $display("FAIL prio_if_rsp k=%0d got v=%b d=%h exp d=11111111", k, if_rsp_valid, if_rsp_data);
         end
      end
   endtask

   task automatic test_arbitration;
      logic [31:0] seen [$];
      logic [31:0] exp_seq [4];
`ifdef MEM_ARB_RR_EN
      exp_seq = '{32'h40, 32'h0, 32'h40, 32'h0};
`else
      exp_seq = '{32'h40, 32'h40, 32'h40, 32'h40};
`endif
      @(negedge clk);
      if_req_valid = 1'b1; if_req_addr = 32'h0;
      d_req_valid = 1'b1; d_req_we = 1'b0; d_req_size = 2'b10; d_req_addr = 32'h40;
      for (int k = 1; k <= 18; k++) begin
         @(negedge clk);
         if (k == 16) clear_inputs();
         #1;
         if (mem_en === 1'b1) seen.push_back(mem_addr);
      end
      total++;
      if (seen.size() != 4) begin
         bad++; $display("FAIL arb_count got=%0d exp=4", seen.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            total++;
            if (seen[i] !== exp_seq[i]) begin
               bad++; $display("FAIL arb_order i=%0d got=%h exp=%h", i, seen[i], exp_seq[i]);
            end
         end
      end
   endtask

   task automatic test_store;
      logic        v_we    [3] = '{1'b1, 1'b1, 1'b0};
      logic [1:0]  v_size  [3] = '{2'b00, 2'b01, 2'b10};
      logic [31:0] v_addr  [3] = '{32'h103, 32'h102, 32'h100};
      logic [31:0] v_wdata [3] = '{32'h123456A5, 32'h0000BEEF, 32'hFFFFFFFF};
      logic [3:0]  e_strb  [3] = '{4'b1000, 4'b1100, 4'b0000};
      logic [31:0] e_wdata [3] = '{32'hA5A5A5A5, 32'hBEEFBEEF, 32'h0};
      logic [31:0] e_rdata [3] = '{32'h0, 32'h0, 32'hBEEF3344};
      logic [31:0] e_mem   [3] = '{32'hA5223344, 32'hBEEF3344, 32'hBEEF3344};
      for (int v = 0; v < 3; v++) begin
         @(negedge clk);
         d_req_valid = 1'b1; d_req_we = v_we[v]; d_req_size = v_size[v];
         d_req_addr = v_addr[v]; d_req_wdata = v_wdata[v];
         for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) clear_inputs();
            #1;
            if (k == 1) begin
               total++;
               if (mem_en !== 1'b1 || mem_we !== v_we[v] || mem_addr !== 32'h100 ||
                   mem_wstrb !== e_strb[v] || (v_we[v] && mem_wdata !== e_wdata[v])) begin
                  bad++;
                  $display("FAIL store_mem v=%0d got en=%b we=%b addr=%h strb=%b wd=%h exp strb=%b wd=%h",
                           v, mem_en, mem_we, mem_addr, mem_wstrb, mem_wdata, e_strb[v], e_wdata[v]);
               end
            end
            total++;
            if (d_rsp_valid !== (k == 4) ||
                (k == 4 && (d_rsp_err !== 1'b0 || d_rsp_data !== e_rdata[v]))) begin
               bad++;
               $display("FAIL store_rsp v=%0d k=%0d got v=%b e=%b d=%h exp d=%h", v, k, d_rsp_valid, d_rsp_err, d_rsp_data, e_rdata[v]);
            end
         end
         total++;
         if (mem[8'h40] !== e_mem[v]) begin
            bad++; $display("FAIL store_memword v=%0d got=%h exp=%h", v, mem[8'h40], e_mem[v]);
         end
      end
   endtask

   task automatic test_misalign;
      logic        v_we   [2] = '{1'b0, 1'b1};
      logic [1:0]  v_size [2] = '{2'b10, 2'b01};
      logic [31:0] v_addr [2] = '{32'h102, 32'h101};
      for (int v = 0; v < 2; v++) begin
         @(negedge clk);
         d_req_valid = 1'b1; d_req_we = v_we[v]; d_req_size = v_size[v];
         d_req_addr = v_addr[v]; d_req_wdata = 32'hFFFFFFFF;
         #1;
         total++;
         if (d_req_ready !== 1'b1) begin
            bad++; $display("FAIL mis_ready v=%0d got=%b exp=1", v, d_req_ready);
         end
         for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) clear_inputs();
            #1;
            total++;
            if (mem_en !== 1'b0) begin
               bad++; $display("FAIL mis_mem_en v=%0d k=%0d got=%b exp=0", v, k, mem_en);
            end
            total++;
            if (d_rsp_valid !== (k == 1) || d_rsp_err !== (k == 1) || (k == 1 && d_rsp_data !== 32'h0)) begin
               bad++; $display("FAIL mis_rsp v=%0d k=%0d got v=%b e=%b d=%h exp v=e=%b d=0", v, k, d_rsp_valid, d_rsp_err, d_rsp_data, k == 1);
            end
            if (k == 2) begin
               total++;
               if (d_req_ready !== 1'b1) begin
                  bad++; $display("FAIL mis_idle v=%0d got ready=%b exp=1", v, d_req_ready);
               end
            end
         end
      end
      total++;
      if (mem[8'h40] !== 32'hBEEF3344) begin
         bad++; $display("FAIL mis_memword got=%h exp=beef3344", mem[8'h40]);
      end
   endtask

   task automatic test_flush;
      @(negedge clk);
      if_req_valid = 1'b1; if_req_addr = 32'h10;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (k == 1) if_req_valid = 1'b0;
         if_flush = (k == 2);
         #1;
         total++;
         if (if_rsp_valid !== 1'b0) begin
            bad++; $display("FAIL flush_kill k=%0d got=%b exp=0", k, if_rsp_valid);
         end
      end
      @(negedge clk);
      if_req_valid = 1'b1; if_req_addr = 32'h20; if_flush = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (k == 1) clear_inputs();
         #1;
         total++;
         if (if_rsp_valid !== (k == 4) || (k == 4 && if_rsp_data !== 32'hCAFEF00D)) begin
            bad++; $display("FAIL flush_next k=%0d got v=%b d=%h exp v=%b d=cafef00d", k, if_rsp_valid, if_rsp_data, k == 4);
         end
      end
   endtask

   task automatic test_reset_mid;
      logic [31:0] lo;
      @(negedge clk);
      if_req_valid = 1'b1; if_req_addr = 32'h10;
      @(negedge clk);
      if_req_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1; if_req_valid = 1'b1; d_req_valid = 1'b1;
      #1;
      lo = {24'd0, if_req_ready, d_req_ready, mem_en, mem_we, if_rsp_valid, d_rsp_valid, d_rsp_err, |mem_wstrb};
      total++;
      if (lo !== 32'd0 || mem_addr !== '0 || if_rsp_data !== '0 || d_rsp_data !== '0) begin
         bad++;
         $display("FAIL midreset_outputs got ctl=%h addr=%h ifd=%h dd=%h exp all 0", lo, mem_addr, if_rsp_data, d_rsp_data);
      end
      @(negedge clk);
      clear_inputs();
      reset = 1'b0;
      #1;
      total++;
      if (d_req_ready !== 1'b1) begin
         bad++; $display("FAIL midreset_ready got=%b exp=1", d_req_ready);
      end
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         #1;
         total++;
         if (if_rsp_valid !== 1'b0 || d_rsp_valid !== 1'b0 || mem_en !== 1'b0) begin
            bad++; $display("FAIL midreset_stale k=%0d got ifv=%b dv=%b en=%b exp 0", k, if_rsp_valid, d_rsp_valid, mem_en);
         end
      end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_priority();
      test_arbitration();
      test_store();
      test_misalign();
      test_flush();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
